// File: rtl/seven_segment_scan_capture.sv
`default_nettype none
// ============================================================================
// seven_segment_scan_capture
// Recovers BCD frames from a multiplexed active-low seven-segment display.
// Rev 1.0
// ============================================================================
module seven_segment_scan_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic                    clck,
  input  logic                    reset,
  input  logic [6:0]              a_to_g,
  input  logic [7:0]              Anode_Activate,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_present,
  output logic [13:0]             value,
  output logic                    frame_valid,
  output logic                    display_on,
  output logic                    seg_error,
  output logic                    anode_error
);

  localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CW = $clog2(NUM_DIGITS + 1);
  localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_an;
  logic [6:0]              r_seg;
  logic [7:0]              r_an_d;
  logic [6:0]              r_seg_d;
  logic [c_SW-1:0]         r_stab;
  logic [c_TW-1:0]         r_tmo;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_dreg;

  logic                    w_change;
  logic                    w_settle;
  logic [c_CW-1:0]         w_low_cnt;
  logic [c_IW-1:0]         w_idx;
  logic                    w_all_high;
  logic                    w_an_ok;
  logic [3:0]              w_bcd;
  logic                    w_seg_valid;
  logic                    w_seg_blank;
  logic                    w_cap;
  logic                    w_an_err_set;
  logic                    w_seg_err_set;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [4*NUM_DIGITS-1:0] w_masked;
  logic [13:0]             w_value;

  // One capture per stable dwell: fire only on the cycle the counter hits the limit
  assign w_change = ({r_an, r_seg} != {r_an_d, r_seg_d});
  assign w_settle = !w_change && (r_stab == c_SW'(SETTLE_CYCLES - 1));

  always_comb begin
    w_low_cnt = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an[i]) begin
        w_low_cnt = w_low_cnt + 1'b1;
        w_idx     = c_IW'(i);
      end
    end
  end

  assign w_all_high = &r_an;
  assign w_an_ok    = (w_low_cnt == c_CW'(1)) && (&r_an[7:NUM_DIGITS]);

  always_comb begin
    w_bcd       = 4'd0;
    w_seg_valid = 1'b1;
    w_seg_blank = 1'b0;
    case (r_seg)
      7'b0000001: w_bcd = 4'd0;
      7'b1001111: w_bcd = 4'd1;
      7'b0010010: w_bcd = 4'd2;
      7'b0000110: w_bcd = 4'd3;
      7'b1001100: w_bcd = 4'd4;
      7'b0100100: w_bcd = 4'd5;
      7'b0100000: w_bcd = 4'd6;
      7'b0001111: w_bcd = 4'd7;
      7'b0000000: w_bcd = 4'd8;
      7'b0000100: w_bcd = 4'd9;
      7'b1111111: begin
        w_seg_valid = 1'b0;
        w_seg_blank = 1'b1;
      end
      default:    w_seg_valid = 1'b0;
    endcase
  end

  assign w_cap         = w_settle && w_an_ok && w_seg_valid;
  assign w_an_err_set  = w_settle && !w_all_high && !w_an_ok;
  assign w_seg_err_set = w_settle && w_an_ok && !w_seg_valid && !w_seg_blank;
  assign w_onehot      = NUM_DIGITS'(1) << w_idx;

  // Digits not lit during the frame are published as zero
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_mask
      assign w_masked[4*g +: 4] = r_seen[g] ? r_dreg[4*g +: 4] : 4'd0;
    end
  endgenerate

  always_comb begin
    w_value = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_value = (w_value * 14'd10) + {10'd0, w_masked[4*i +: 4]};
    end
  end

  always_ff @(posedge clck) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_an          <= '1;
      r_seg         <= '1;
      r_an_d        <= '1;
      r_seg_d       <= '1;
      r_stab        <= '0;
      r_tmo         <= '0;
      r_seen        <= '0;
      r_dreg        <= '0;
      digits        <= '0;
      digit_present <= '0;
      value         <= '0;
      frame_valid   <= 1'b0;
      display_on    <= 1'b0;
      seg_error     <= 1'b0;
      anode_error   <= 1'b0;
    end else begin
      r_an    <= Anode_Activate;
      r_seg   <= a_to_g;
      r_an_d  <= r_an;
      r_seg_d <= r_seg;

      if (w_change)
        r_stab <= '0;
      else if (r_stab != c_SW'(SETTLE_CYCLES))
        r_stab <= r_stab + 1'b1;

      frame_valid <= 1'b0;
      seg_error   <= w_seg_err_set | (seg_error & ~err_clr);
      anode_error <= w_an_err_set | (anode_error & ~err_clr);

      // A revisit of an already-seen digit closes the current frame
      if (w_cap) begin
        if (r_seen[w_idx]) begin
          digits        <= w_masked;
          digit_present <= r_seen;
          value         <= w_value;
          frame_valid   <= 1'b1;
          r_seen        <= w_onehot;
        end else begin
          r_seen[w_idx] <= 1'b1;
        end
        r_dreg[{w_idx, 2'b00} +: 4] <= w_bcd;
      end

      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_cap) begin
            r_state    <= S_SCAN;
            display_on <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_cap) begin
            r_tmo <= '0;
          end else if (r_tmo >= c_TW'(TIMEOUT_CYCLES - 1)) begin
            r_state       <= S_IDLE;
            display_on    <= 1'b0;
            digit_present <= '0;
            r_seen        <= '0;
            r_tmo         <= c_TW'(TIMEOUT_CYCLES);
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          display_on <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_capture.sv
`default_nettype none
// Bench for seven_segment_scan_capture: directed display scans with a frame scoreboard.
module tb_seven_segment_scan_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 200;
  localparam int DWELL  = 40;

  logic        clck = 1'b0;
  logic        reset;
  logic [6:0]  a_to_g;
  logic [7:0]  Anode_Activate;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_present;
  logic [13:0] value;
  logic        frame_valid;
  logic        display_on;
  logic        seg_error;
  logic        anode_error;

  seven_segment_scan_capture #(
    .NUM_DIGITS    (4),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clck          (clck),
    .reset         (reset),
    .a_to_g        (a_to_g),
    .Anode_Activate(Anode_Activate),
    .err_clr       (err_clr),
    .digits        (digits),
    .digit_present (digit_present),
    .value         (value),
    .frame_valid   (frame_valid),
    .display_on    (display_on),
    .seg_error     (seg_error),
    .anode_error   (anode_error)
  );

  always #5 clck = ~clck;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  present;
    logic [13:0] value;
  } frame_t;

  frame_t      sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_frames = 0;
  int          n_pushed = 0;
  logic [3:0]  m_dreg[4];
  logic [3:0]  m_seen;
  logic [13:0] m_last_value;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    frame_t f;
    logic [3:0] dv[4];
    for (int i = 0; i < 4; i++) dv[i] = m_seen[i] ? m_dreg[i] : 4'd0;
    f.digits  = {dv[3], dv[2], dv[1], dv[0]};
    f.present = m_seen;
    f.value   = 14'(dv[3] * 1000 + dv[2] * 100 + dv[1] * 10 + dv[0]);
    m_last_value = f.value;
    sb.push_back(f);
    n_pushed++;
    m_seen = 4'b0000;
  endtask

  task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
    Anode_Activate = an;
    a_to_g         = seg;
    repeat (n) @(negedge clck);
  endtask

  task automatic visit(input int idx, input int d);
    if (m_seen[idx]) push_frame();
    m_seen[idx] = 1'b1;
    m_dreg[idx] = 4'(d);
    hold(~(8'd1 << idx), seg_of(d), DWELL);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clck);
    err_clr = 1'b0;
    @(negedge clck);
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame
  always @(negedge clck) begin
    if (frame_valid) begin
      frame_t f;
      n_frames++;
      chk("frame_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        f = sb.pop_front();
        chk("frame_digits", digits, f.digits);
        chk("frame_present", digit_present, f.present);
        chk("frame_value", value, f.value);
      end
    end
  end

  initial begin
    int k;
    bit fell;
    m_seen         = 4'b0000;
    m_last_value   = '0;
    for (int i = 0; i < 4; i++) m_dreg[i] = 4'd0;
    reset          = 1'b1;
    err_clr        = 1'b0;
    Anode_Activate = 8'hFF;
    a_to_g         = 7'h7F;
    repeat (3) @(negedge clck);
    chk("rst_digits", digits, 0);
    chk("rst_present", digit_present, 0);
    chk("rst_value", value, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_errors", {seg_error, anode_error}, 0);
    reset = 1'b0;
    @(negedge clck);

    // Patterns shorter than the settle time never capture
    for (int i = 0; i < 12; i++)
      hold((i % 2) ? 8'b11111101 : 8'b11111110, seg_of((i % 2) ? 4 : 7), 10);
    chk("fast_display_on", display_on, 0);
    chk("fast_frames", n_frames, 0);
    chk("fast_errors", {seg_error, anode_error}, 0);

    // Full four-digit scan
    visit(0, 8); visit(1, 3); visit(2, 2); visit(3, 1); visit(0, 8);
    chk("scan_display_on", display_on, 1);
    // Blank lit digit is ignored; missing digits publish as 0
    hold(8'b11111011, 7'h7F, DWELL);
    visit(1, 5); visit(0, 9);
    chk("blank_no_seg_error", seg_error, 0);

    // Unrecognised pattern on a lit anode
    hold(8'b11111011, 7'b1111110, DWELL);
    chk("seg_error_set", seg_error, 1);
    chk("seg_error_no_anode", anode_error, 0);
    pulse_clr();
    chk("seg_error_clr", seg_error, 0);

    hold(8'b11111100, seg_of(3), DWELL);
    chk("anode_two_low", anode_error, 1);
    pulse_clr();
    chk("anode_error_clr", anode_error, 0);
    hold(8'b11101111, seg_of(3), DWELL);
    chk("anode_upper_low", anode_error, 1);
    pulse_clr();

    // Errors left seen untouched: next frame holds digits 1,0 only
    visit(1, 4); visit(0, 7); visit(1, 4); visit(0, 7);
    chk("scan47_display_on", display_on, 1);

    // Display goes dark: timeout with value held
    hold(8'hFF, 7'h7F, 150);
    chk("tmo_still_on", display_on, 1);
    k = 150;
    fell = 1'b0;
    for (int i = 0; i < 100 && !fell; i++) begin
      @(negedge clck);
      k++;
      if (!display_on) fell = 1'b1;
    end
    chk("tmo_fell", fell, 1);
    chk("tmo_window", (k >= 170 && k <= 185), 1);
    chk("tmo_present", digit_present, 0);
    chk("tmo_value_hold", value, m_last_value);
    chk("tmo_digits_hold", digits, 16'h0047);
    m_seen = 4'b0000;

    // Reset in the middle of a digit1 dwell
    visit(0, 5);
    hold(8'b11111101, seg_of(6), 20);
    reset = 1'b1;
    @(negedge clck);
    chk("mid_rst_digits", digits, 0);
    chk("mid_rst_value", value, 0);
    chk("mid_rst_display_on", display_on, 0);
    chk("mid_rst_fv", frame_valid, 0);
    reset = 1'b0;
    m_seen = 4'b0000;
    visit(1, 6); visit(0, 5); visit(1, 6);

    hold(8'hFF, 7'h7F, 10);
    chk("sb_drained", sb.size(), 0);
    chk("frame_count", n_frames, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
